// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with IF/ID register and one-entry hold buffer
// One imem request in flight; a returned word lands in the hold buffer while IF/ID is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hb_pc_q, hb_pc_d;
  logic [31:0] hb_instr_q, hb_instr_d;
  logic        req_d;
  logic [31:0] addr_d;
  logic [31:0] if_pc_d, if_instr_d;
  logic        if_valid_d;
  logic [31:0] addr_inc;

  assign addr_inc = imem_addr + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      fetch_pc_q  <= RESET_PC;
      hb_pc_q     <= 32'd0;
      hb_instr_q  <= 32'd0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      IF_ID_PC    <= 32'd0;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hb_pc_q     <= hb_pc_d;
      hb_instr_q  <= hb_instr_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      IF_ID_PC    <= if_pc_d;
      IF_ID_Instr <= if_instr_d;
      IF_ID_Valid <= if_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hb_pc_d    = hb_pc_q;
    hb_instr_d = hb_instr_q;
    req_d      = imem_req;
    addr_d     = imem_addr;
    // Nothing delivered: a stalled IF/ID holds, otherwise it takes a bubble.
    if (IF_ID_Write) begin
      if_pc_d    = IF_ID_PC;
      if_instr_d = IF_ID_Instr;
      if_valid_d = IF_ID_Valid;
    end else begin
      if_pc_d    = 32'd0;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end

    if (flush) begin
      fetch_pc_d = branch_target;
      hb_pc_d    = 32'd0;
      hb_instr_d = 32'd0;
      if_pc_d    = 32'd0;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
      case (state_q)
        S_WAIT: begin
          // An unacked request cannot be withdrawn; drain it in DRAIN.
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_HOLD:  state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (PC_Write) begin
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            fetch_pc_d = addr_inc;
            if (!IF_ID_Write) begin
              if_pc_d    = imem_addr;
              if_instr_d = imem_rdata;
              if_valid_d = 1'b1;
              if (PC_Write) begin
                addr_d = addr_inc;
              end else begin
                req_d   = 1'b0;
                state_d = S_FETCH;
              end
            end else begin
              hb_pc_d    = imem_addr;
              hb_instr_d = imem_rdata;
              req_d      = 1'b0;
              state_d    = S_HOLD;
            end
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_HOLD: begin
          if (!IF_ID_Write) begin
            if_pc_d    = hb_pc_q;
            if_instr_d = hb_instr_q;
            if_valid_d = 1'b1;
            if (PC_Write) begin
              req_d   = 1'b1;
              addr_d  = fetch_pc_q;
              state_d = S_WAIT;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. It acts on the load-use stall outputs (PC_Write, IF_ID_Write) from the ID-stage hazard unit and on the EX-stage branch/jump flush. It drives a variable-latency instruction-memory port with one outstanding request, and buffers one returned instruction while IF/ID is stalled.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP_INSTR, 32'h0000_0013, encoding loaded into IF/ID as a bubble (addi x0,x0,0)
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- PC_Write  in  1  1 = fetch may advance to a new address; 0 = no new request may be issued
- IF_ID_Write  in  1  1 = hold IF/ID contents (stall); 0 = IF/ID loads
- flush  in  1  branch/jump taken in EX; redirect to branch_target
- branch_target  in  32  redirect address, sampled when flush=1
- imem_req  out  1  registered request; held high until acked
- imem_addr  out  32  registered fetch address; stable while imem_req=1
- imem_ack  in  1  imem_rdata valid this cycle; ignored when imem_req=0
- imem_rdata  in  32  returned instruction
- IF_ID_PC  out  32  PC of the instruction in IF/ID
- IF_ID_Instr  out  32  instruction in IF/ID
- IF_ID_Valid  out  1  1 = real instruction; 0 = bubble

## Operation
- Registers:
  - fetch_pc: next address to request.
  - State ∈ {FETCH, WAIT, DRAIN, HOLD}.
  - Hold buffer: hb_pc, hb_instr.
- "Accept" means imem_ack=1 in WAIT or DRAIN.
- **flush has top priority in every state, and overrides IF_ID_Write.** At the edge where flush=1:
  - IF/ID is set to {PC 0, NOP_INSTR, Valid 0}.
  - The hold buffer is discarded.
  - fetch_pc is set to branch_target.
- **FETCH:** imem_req=0.
  - If PC_Write=1 and no flush: imem_req←1, imem_addr←fetch_pc, go to WAIT.
- **WAIT:** imem_req=1.
  - On accept with flush=1: drop the data, imem_req←0, go to FETCH.
  - On accept with IF_ID_Write=0: IF/ID←{imem_addr, imem_rdata, 1} and fetch_pc←imem_addr+4. Then:
    - if PC_Write=1, stay in WAIT with imem_addr←imem_addr+4 (back-to-back request);
    - otherwise imem_req←0 and go to FETCH.
  - On accept with IF_ID_Write=1: hb←{imem_addr, imem_rdata}, fetch_pc←imem_addr+4, imem_req←0, go to HOLD.
  - If flush=1 with no ack: go to DRAIN (the request stays high at the old address).
- **DRAIN:** imem_req=1 at the stale address.
  - On accept: discard the data, imem_req←0, go to FETCH.
  - Additional flushes in DRAIN only update fetch_pc.
- **HOLD:** imem_req=0.
  - When IF_ID_Write=0 (and no flush): IF/ID←{hb_pc, hb_instr, 1}. Then:
    - if PC_Write=1: imem_req←1, imem_addr←fetch_pc, go to WAIT;
    - otherwise go to FETCH.
- **IF/ID when nothing is delivered** (no accept-into-IF/ID, no HOLD drain):
  - IF_ID_Write=0: IF/ID←bubble.
  - IF_ID_Write=1: IF/ID holds.
- Address arithmetic is 32-bit, modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] are passed through unchecked.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=FETCH, fetch_pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0
  - hb cleared
- Reset mid-request abandons the request. Memory must tolerate req dropping without an ack.
- First request: imem_req rises at the first clk edge after rst_n deasserts, provided PC_Write=1.
- imem_ack may arrive no earlier than the cycle after imem_req rises. There is no upper latency bound.
- With a 1-cycle memory and no stalls, IF/ID receives one new valid instruction every cycle.
- Instruction-to-IF/ID latency: one edge after ack.
- Flush to new request:
  - no outstanding request: 2 edges;
  - from DRAIN: edge after stale ack, plus 1.
- At most one request is outstanding. imem_addr never changes while imem_req=1 without an ack.

## Test plan
- Reset, then 1-cycle-ack memory, stalls low → imem_addr 0,4,8,… on consecutive cycles; IF_ID_PC follows one cycle later with Valid=1; no bubbles.
- Load-use stall: PC_Write=0, IF_ID_Write=1 for 1 cycle while the ack for 0x10 arrives → instruction enters hb; IF/ID keeps 0x0C for that cycle, then shows 0x10; next request is 0x14; nothing lost or duplicated.
- flush=1, branch_target=0x200, with request 0x20 outstanding and ack 3 cycles later → DRAIN; stale data discarded; IF/ID bubbles (Valid=0, Instr=0x13); next imem_addr=0x200.
- flush and IF_ID_Write=1 in the same cycle → IF/ID becomes bubble anyway; fetch redirects to target.
- fetch_pc=32'hFFFF_FFFC accepted → next imem_addr=0.
- rst_n pulsed low while in WAIT → outputs return to reset values immediately; the late ack is ignored; fetch restarts at RESET_PC.
